// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU ops plus an iterative 32-step shift-add multiplier,
// with a valid/ready input handshake and a registered register-file write-back port.
module exec_unit #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op,
  input  logic [XLEN-1:0]       rs1_val,
  input  logic [XLEN-1:0]       rs2_val,
  input  logic [REG_ADDR_W-1:0] rd_in,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]       wb_data,
  output logic                  busy
);

  localparam int CNT_W = $clog2(XLEN);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam logic [XLEN-1:0]       XLEN_ZERO = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]       XLEN_ONE  = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [REG_ADDR_W-1:0] RD_ZERO   = {REG_ADDR_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]      CNT_LAST  = {CNT_W{1'b1}};

  logic [1:0]            state_r;
  logic [XLEN-1:0]       mcand_r;
  logic [XLEN-1:0]       mplier_r;
  logic [XLEN-1:0]       acc_r;
  logic [CNT_W-1:0]      count_r;
  logic [REG_ADDR_W-1:0] rd_r;
  logic                  wb_we_r;
  logic [XLEN-1:0]       acc_step_s;
  logic                  accept_s;

  // Single-cycle ALU; SUB is two's-complement add of the inverted operand.
  function automatic logic [XLEN-1:0] alu_f(input logic [2:0] f_op,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    case (f_op)
      OP_ADD:  alu_f = a + b;
      OP_SUB:  alu_f = a + ~b + XLEN_ONE;
      OP_AND:  alu_f = a & b;
      OP_OR:   alu_f = a | b;
      OP_XOR:  alu_f = a ^ b;
      OP_SLL:  alu_f = a << b[CNT_W-1:0];
      OP_SRL:  alu_f = a >> b[CNT_W-1:0];
      default: alu_f = XLEN_ZERO;
    endcase
  endfunction

  // Handshake status; reset forces the stage to look empty and not ready.
  always_comb begin
    in_ready = (state_r == ST_IDLE) && !reset;
    busy     = (state_r != ST_IDLE) && !reset;
    accept_s = in_valid && in_ready;
  end

  // One shift-add multiply step: conditionally add the shifted multiplicand.
  always_comb begin
    if (mplier_r[0]) begin
      acc_step_s = acc_r + mcand_r;
    end else begin
      acc_step_s = acc_r;
    end
  end

  // Write enable is additionally gated by reset so x0-style spurious writes never escape.
  always_comb begin
    wb_we = wb_we_r && !reset;
  end

  // Main state machine, operand latches and registered write-back port.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      mcand_r  <= XLEN_ZERO;
      mplier_r <= XLEN_ZERO;
      acc_r    <= XLEN_ZERO;
      count_r  <= CNT_ZERO;
      rd_r     <= RD_ZERO;
      wb_we_r  <= 1'b0;
      wb_rd    <= RD_ZERO;
      wb_data  <= XLEN_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          wb_we_r <= 1'b0;
          if (accept_s) begin
            rd_r <= rd_in;
            if (op == OP_MUL) begin
              mcand_r  <= rs1_val;
              mplier_r <= rs2_val;
              acc_r    <= XLEN_ZERO;
              count_r  <= CNT_ZERO;
              state_r  <= ST_MUL;
            end else begin
              wb_rd   <= rd_in;
              wb_data <= alu_f(op, rs1_val, rs2_val);
              wb_we_r <= (rd_in != RD_ZERO);
              state_r <= ST_WB;
            end
          end
        end
        ST_MUL: begin
          acc_r    <= acc_step_s;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          count_r  <= count_r + CNT_ONE;
          // Last step: the final partial product goes straight to the write port.
          if (count_r == CNT_LAST) begin
            wb_rd   <= rd_r;
            wb_data <= acc_step_s;
            wb_we_r <= (rd_r != RD_ZERO);
            state_r <= ST_WB;
          end
        end
        ST_WB: begin
          wb_we_r <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          wb_we_r <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: expected write-backs go into a queue at issue time and a
// negedge monitor pops and compares every wb_we pulse; timing/boundary checks run inline.
module tb_exec_unit;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  rd_in;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  exec_unit #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (wb_we === 1'b1) begin
      wb_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_wb: got rd=%0d data=%h expected no write", wb_rd, wb_data);
      end else begin
        e = exp_q.pop_front();
        if (wb_rd !== e.rd || wb_data !== e.data) begin
          errors++;
          $display("FAIL wb_compare: got rd=%0d data=%h expected rd=%0d data=%h",
                   wb_rd, wb_data, e.rd, e.data);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int edges);
    logic rdy;
    int   n;
    op = o; rs1_val = a; rs2_val = b; rd_in = rd; in_valid = 1'b1;
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 200) begin
      rdy = in_ready;
      @(posedge clock);
      n++;
      if (!rdy) @(negedge clock);
    end
    checks++;
    if (!rdy) begin
      errors++;
      $display("FAIL accept_timeout: got no accept after %0d edges expected accept", n);
    end
    @(negedge clock);
    in_valid = 1'b0;
    edges = n;
  endtask

  task automatic alu_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    int n;
    wb_t e;
    e.rd = rd;
    e.data = exp;
    if (rd != 5'd0) exp_q.push_back(e);
    issue(o, a, b, rd, n);
    chk({name, "_we"}, {31'd0, wb_we}, {31'd0, (rd != 5'd0)});
    chk({name, "_rd"}, {27'd0, wb_rd}, {27'd0, rd});
    chk({name, "_data"}, wb_data, exp);
    chk({name, "_notready_wb"}, {31'd0, in_ready}, 32'd0);
    @(negedge clock);
    chk({name, "_ready_after"}, {31'd0, in_ready}, 32'd1);
    chk({name, "_we_drop"}, {31'd0, wb_we}, 32'd0);
  endtask

  task automatic mul_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp);
    int n;
    int nb;
    int we_at;
    wb_t e;
    e.rd = rd;
    e.data = exp;
    if (rd != 5'd0) exp_q.push_back(e);
    issue(3'b111, a, b, rd, n);
    nb = 0;
    we_at = 0;
    while (busy && nb < 100) begin
      nb++;
      if (wb_we) we_at = nb;
      @(negedge clock);
    end
    chk({name, "_busy_cycles"}, nb, 32'd33);
    chk({name, "_we_cycle"}, we_at, 32'd33);
    chk({name, "_ready_after"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int  n;
    wb_t e;
    reset = 1'b1; in_valid = 1'b0; op = 3'd0; rs1_val = 32'd0; rs2_val = 32'd0; rd_in = 5'd0;
    repeat (3) @(negedge clock);
    chk("rst_we", {31'd0, wb_we}, 32'd0);
    chk("rst_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst_data", wb_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);
    @(negedge clock);

    alu_op("add",      3'b000, 32'd5,          32'd7,          5'd3,  32'd12);
    alu_op("sub_wrap", 3'b001, 32'd0,          32'd1,          5'd4,  32'hFFFF_FFFF);
    alu_op("srl",      3'b110, 32'h8000_0000,  32'h21,         5'd6,  32'h4000_0000);
    alu_op("sll0",     3'b101, 32'h1234_5678,  32'h20,         5'd7,  32'h1234_5678);
    alu_op("sll",      3'b101, 32'h0000_0003,  32'h4,          5'd8,  32'h0000_0030);
    alu_op("and",      3'b010, 32'hF0F0_F0F0,  32'hFF00_FF00,  5'd9,  32'hF000_F000);
    alu_op("or",       3'b011, 32'h0F0F_0000,  32'h0000_00F0,  5'd10, 32'h0F0F_00F0);
    alu_op("xor",      3'b100, 32'hAAAA_5555,  32'hFFFF_0000,  5'd11, 32'h5555_5555);
    alu_op("add_wrap", 3'b000, 32'hFFFF_FFFF,  32'd2,          5'd31, 32'd1);
    alu_op("add_x0",   3'b000, 32'd1,          32'd1,          5'd0,  32'd2);

    mul_op("mul",       32'd1234,       32'd5678,       5'd5,  32'd7006652);
    mul_op("mul_trunc", 32'h0001_0000,  32'h0001_0000,  5'd12, 32'd0);
    mul_op("mul_ones",  32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd13, 32'd1);

    // Stall: an AND held valid during a MUL is taken only on the first IDLE cycle.
    e.rd = 5'd14; e.data = 32'd12; exp_q.push_back(e);
    issue(3'b111, 32'd3, 32'd4, 5'd14, n);
    e.rd = 5'd15; e.data = 32'h0000_F000; exp_q.push_back(e);
    issue(3'b010, 32'h0000_F0F0, 32'h0000_FF00, 5'd15, n);
    chk("stall_accept_edges", n, 32'd34);
    chk("stall_and_we", {31'd0, wb_we}, 32'd1);
    @(negedge clock);

    // Reset ten cycles into a MUL: the operation must vanish without a write.
    issue(3'b111, 32'd1234, 32'd5678, 5'd16, n);
    repeat (9) @(negedge clock);
    chk("mid_mul_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("mulrst_busy", {31'd0, busy}, 32'd0);
    chk("mulrst_ready", {31'd0, in_ready}, 32'd0);
    chk("mulrst_we", {31'd0, wb_we}, 32'd0);
    chk("mulrst_data", wb_data, 32'd0);
    reset = 1'b0;
    #1;
    chk("mulrst_ready_after", {31'd0, in_ready}, 32'd1);
    repeat (40) @(negedge clock);
    chk("mulrst_idle", {31'd0, busy}, 32'd0);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
